// File: rtl/sprite_frame_sync_ctrl.sv
// sprite_frame_sync_ctrl: double-buffered sprite register bank committed at vblank start,
// plus frame counter and frame-locked animation phase.
`default_nettype none

module sprite_frame_sync_ctrl #(
  parameter int NUM_REGS = 16,
  parameter int DATA_W   = 16,
  parameter int VACTIVE  = 480,
  parameter int ANIM_DIV = 6,
  parameter int ANIM_W   = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         chipselect,
  input  logic                         write,
  input  logic [8:0]                   address,
  input  logic [31:0]                  writedata,
  input  logic [9:0]                   vcount,
  output logic [NUM_REGS*DATA_W-1:0]   active_regs,
  output logic                         commit_pulse,
  output logic                         frame_tick,
  output logic [15:0]                  frame_count,
  output logic [ANIM_W-1:0]            anim_state,
  output logic                         pending
);

  localparam int          IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int          DIV_W      = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam logic [8:0]  CTRL_ADDR  = 9'h1FF;
  localparam logic [9:0]  NUM_REGS_L = 10'(NUM_REGS);
  localparam logic [9:0]  VACTIVE_L  = 10'(VACTIVE);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(ANIM_DIV - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DIRTY = 2'd1;
  localparam logic [1:0] S_ARMED = 2'd2;

  logic [1:0]                 state_q, state_d;
  logic [NUM_REGS*DATA_W-1:0] shadow_q;
  logic [NUM_REGS*DATA_W-1:0] active_q;
  logic [9:0]                 vprev_q;
  logic                       auto_q;
  logic                       pause_q;
  logic                       commit_pulse_q;
  logic                       frame_tick_q;
  logic [15:0]                frame_count_q;
  logic [DIV_W-1:0]           div_q;
  logic [ANIM_W-1:0]          anim_q;

  logic             wr_en;
  logic             data_wr;
  logic             ctrl_wr;
  logic             commit_wr;
  logic             vb;
  logic             do_commit;
  logic [IDX_W-1:0] wr_idx;

  assign wr_en     = chipselect && write;
  assign data_wr   = wr_en && ({1'b0, address} < NUM_REGS_L);
  assign ctrl_wr   = wr_en && (address == CTRL_ADDR);
  assign commit_wr = ctrl_wr && writedata[1];
  assign wr_idx    = address[IDX_W-1:0];
  assign vb        = (vcount == VACTIVE_L) && (vprev_q != VACTIVE_L);

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state; a COMMIT in the vblank cycle re-arms for the following frame
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (data_wr)        state_d = S_DIRTY;
        else if (commit_wr) state_d = S_ARMED;
      end
      S_DIRTY, S_ARMED: begin
        if (do_commit) begin
          if (commit_wr)    state_d = S_ARMED;
          else if (data_wr) state_d = S_DIRTY;
          else              state_d = S_IDLE;
        end else if (commit_wr) begin
          state_d = S_ARMED;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    pending   = 1'b0;
    do_commit = 1'b0;
    case (state_q)
      S_DIRTY: begin
        pending   = 1'b1;
        do_commit = vb && auto_q;
      end
      S_ARMED: begin
        pending   = 1'b1;
        do_commit = vb;
      end
      default: begin
        pending   = 1'b0;
        do_commit = 1'b0;
      end
    endcase
  end

  // Register bank: the copy uses the pre-write shadow when both happen together
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_q       <= '0;
      active_q       <= '0;
      commit_pulse_q <= 1'b0;
      auto_q         <= 1'b1;
      pause_q        <= 1'b0;
    end else begin
      commit_pulse_q <= do_commit;
      if (data_wr)
        shadow_q[int'(wr_idx)*DATA_W +: DATA_W] <= writedata[DATA_W-1:0];
      if (do_commit)
        active_q <= shadow_q;
      if (ctrl_wr) begin
        auto_q  <= writedata[0];
        pause_q <= writedata[2];
      end
    end
  end

  // Frame timing and animation phase
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vprev_q       <= '0;
      frame_tick_q  <= 1'b0;
      frame_count_q <= '0;
      div_q         <= '0;
      anim_q        <= '0;
    end else begin
      vprev_q      <= vcount;
      frame_tick_q <= vb;
      if (vb) begin
        frame_count_q <= frame_count_q + 16'd1;
        if (!pause_q) begin
          if (div_q == DIV_LAST) begin
            div_q  <= '0;
            anim_q <= anim_q + ANIM_W'(1);
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end
      end
    end
  end

  assign active_regs  = active_q;
  assign commit_pulse = commit_pulse_q;
  assign frame_tick   = frame_tick_q;
  assign frame_count  = frame_count_q;
  assign anim_state   = anim_q;

endmodule

`default_nettype wire

// File: tb/tb_sprite_frame_sync_ctrl.sv
// tb_sprite_frame_sync_ctrl: directed stimulus with a commit scoreboard for sprite_frame_sync_ctrl.
`default_nettype none

module tb_sprite_frame_sync_ctrl;

  logic         clk = 1'b0;
  logic         reset;
  logic         chipselect;
  logic         write;
  logic [8:0]   address;
  logic [31:0]  writedata;
  logic [9:0]   vcount;
  logic [255:0] active_regs;
  logic         commit_pulse;
  logic         frame_tick;
  logic [15:0]  frame_count;
  logic [1:0]   anim_state;
  logic         pending;

  sprite_frame_sync_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .chipselect   (chipselect),
    .write        (write),
    .address      (address),
    .writedata    (writedata),
    .vcount       (vcount),
    .active_regs  (active_regs),
    .commit_pulse (commit_pulse),
    .frame_tick   (frame_tick),
    .frame_count  (frame_count),
    .anim_state   (anim_state),
    .pending      (pending)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [255:0] exp_q[$];
  logic [255:0] m_shadow;
  logic [15:0]  m_fc;
  int           m_div;
  logic [1:0]   m_anim;
  logic         m_pause;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_shadow = '0;
    m_fc     = '0;
    m_div    = 0;
    m_anim   = '0;
    m_pause  = 1'b0;
  endtask

  task automatic model_frame();
    m_fc = m_fc + 16'd1;
    if (!m_pause) begin
      if (m_div == 5) begin
        m_div  = 0;
        m_anim = m_anim + 2'd1;
      end else begin
        m_div = m_div + 1;
      end
    end
  endtask

  task automatic wr(input logic [8:0] a, input logic [31:0] d);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    step();
    chipselect = 1'b0; write = 1'b0;
    if (a < 9'd16) m_shadow[int'(a)*16 +: 16] = d[15:0];
    else if (a == 9'h1FF) m_pause = d[2];
  endtask

  task automatic vblank();
    vcount = 10'd480;
    step();
    model_frame();
    check("frame_tick_hi", {31'd0, frame_tick}, 32'd1);
    check("frame_count", {16'd0, frame_count}, {16'd0, m_fc});
    check("anim_state", {30'd0, anim_state}, {30'd0, m_anim});
    vcount = 10'd481;
    step();
    check("frame_tick_lo", {31'd0, frame_tick}, 32'd0);
  endtask

  function automatic logic [31:0] areg(input int i);
    return {16'd0, active_regs[i*16 +: 16]};
  endfunction

  // Every commit pulse must match the next expected register image
  always @(negedge clk) begin
    if (reset === 1'b0 && commit_pulse === 1'b1) begin
      n_cmp++;
      assert (exp_q.size() != 0) else begin
        n_err++;
        $error("FAIL unexpected_commit: observed=%0h expected=no commit", active_regs);
      end
      if (exp_q.size() != 0) begin
        logic [255:0] e;
        e = exp_q.pop_front();
        assert (active_regs === e) else begin
          n_err++;
          $error("FAIL commit_image: observed=%0h expected=%0h", active_regs, e);
        end
      end
    end
  end

  initial begin
    logic [255:0] snap_active;
    logic [15:0]  snap_fc;
    logic [1:0]   snap_anim;

    reset = 1'b1; chipselect = 1'b0; write = 1'b0;
    address = '0; writedata = '0; vcount = 10'd100;
    model_reset();
    repeat (3) step();
    reset = 1'b0;
    step();

    // T1: reset state
    check("rst_active", {31'd0, active_regs == '0}, 32'd1);
    check("rst_commit", {31'd0, commit_pulse}, 32'd0);
    check("rst_tick", {31'd0, frame_tick}, 32'd0);
    check("rst_fc", {16'd0, frame_count}, 32'd0);
    check("rst_anim", {30'd0, anim_state}, 32'd0);
    check("rst_pending", {31'd0, pending}, 32'd0);

    // T2: auto commit at vblank
    wr(9'd0, 32'h0064);
    wr(9'd1, 32'h00C8);
    check("t2_pending", {31'd0, pending}, 32'd1);
    vcount = 10'd479;
    step();
    check("t2_hold_reg0", areg(0), 32'd0);
    exp_q.push_back(m_shadow);
    vblank();
    check("t2_reg0", areg(0), 32'h64);
    check("t2_reg1", areg(1), 32'hC8);
    check("t2_pulse_once", {31'd0, commit_pulse}, 32'd0);
    check("t2_pending_clr", {31'd0, pending}, 32'd0);

    // T3: manual commit
    wr(9'h1FF, 32'h0);
    wr(9'd2, 32'h01F4);
    repeat (3) vblank();
    check("t3_reg2_held", areg(2), 32'd0);
    check("t3_pending", {31'd0, pending}, 32'd1);
    wr(9'h1FF, 32'h2);
    exp_q.push_back(m_shadow);
    vblank();
    check("t3_reg2", areg(2), 32'h1F4);
    check("t3_pending_clr", {31'd0, pending}, 32'd0);
    wr(9'd3, 32'h0009);
    vblank();
    check("t3_auto_off", areg(3), 32'd0);
    check("t3_still_dirty", {31'd0, pending}, 32'd1);

    // T4: data write collides with the vblank cycle
    wr(9'h1FF, 32'h1);
    exp_q.push_back(m_shadow);
    vcount = 10'd480;
    chipselect = 1'b1; write = 1'b1; address = 9'd3; writedata = 32'h5;
    step();
    chipselect = 1'b0; write = 1'b0;
    m_shadow[3*16 +: 16] = 16'h5;
    model_frame();
    check("t4_fc", {16'd0, frame_count}, {16'd0, m_fc});
    vcount = 10'd481;
    step();
    check("t4_reg3_old", areg(3), 32'h9);
    check("t4_pending", {31'd0, pending}, 32'd1);
    exp_q.push_back(m_shadow);
    vblank();
    check("t4_reg3_new", areg(3), 32'h5);
    check("t4_pending_clr", {31'd0, pending}, 32'd0);

    // T1 (mid-run): asynchronous reset discards pending writes
    wr(9'd7, 32'h1234);
    #3 reset = 1'b1;
    #1;
    check("midrst_pending", {31'd0, pending}, 32'd0);
    check("midrst_active", {31'd0, active_regs == '0}, 32'd1);
    check("midrst_fc", {16'd0, frame_count}, 32'd0);
    model_reset();
    step();
    reset = 1'b0;
    step();

    // T5: animation phase, then pause
    for (int f = 0; f < 24; f++) vblank();
    check("t5_anim_wrap", {30'd0, anim_state}, 32'd0);
    check("t5_fc24", {16'd0, frame_count}, 32'd24);
    wr(9'h1FF, 32'h5);
    for (int f = 0; f < 10; f++) vblank();
    check("t5_frozen", {30'd0, anim_state}, 32'd0);
    check("t5_fc34", {16'd0, frame_count}, 32'd34);
    wr(9'h1FF, 32'h1);
    for (int f = 0; f < 6; f++) vblank();
    check("t5_resume", {30'd0, anim_state}, 32'd1);

    // T6: frame counter wrap, then ignored addresses
    force dut.frame_count_q = 16'hFFFE;
    #1;
    release dut.frame_count_q;
    m_fc = 16'hFFFE;
    vblank();
    vblank();
    check("t6_wrapped", {16'd0, frame_count}, 32'd0);
    wr(9'd5, 32'hBEEF);
    exp_q.push_back(m_shadow);
    vblank();
    snap_active = active_regs;
    snap_fc     = frame_count;
    snap_anim   = anim_state;
    wr(9'h100, 32'hFFFF_FFFF);
    wr(9'h010, 32'hFFFF_FFFF);
    step();
    check("t6_ign_pending", {31'd0, pending}, 32'd0);
    check("t6_ign_active", {31'd0, active_regs === snap_active}, 32'd1);
    check("t6_ign_fc", {16'd0, frame_count}, {16'd0, snap_fc});
    check("t6_ign_anim", {30'd0, anim_state}, {30'd0, snap_anim});
    check("t6_ign_commit", {31'd0, commit_pulse}, 32'd0);
    vblank();
    check("t6_reg5", areg(5), 32'hBEEF);

    step();
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
